// File: rtl/piso_pkg.sv
// Shared definitions for the framed PISO transmitter:
// state encoding and the fixed line levels of the frame.
package piso_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/piso_serializer_bit_tick_gen.sv
// Bit-period timer for the serializer.
// Counts 0..TICK_DIV-1 and raises tick during the last cycle of each bit period.
// tick is held in its own flop, precomputed from the next count value,
// so it is glitch-free and lines up exactly with count == TICK_DIV-1.
// clr restarts the period: the following cycle is count 0 of a fresh bit.
module bit_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count: restart on clear or after the last cycle of a period, else advance
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (tick_q) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_d == LAST);
  end

  // Counter and tick flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/piso_serializer.sv
// Framed parallel-in serial-out transmitter (start 0, data, optional parity, stop 1).
// A word is taken over a valid/ready handshake while idle and shifted out one bit
// per TICK_DIV clock cycles. Line, ready and busy are registered, computed from
// the next state so they change on the same edge the state does.
// Optional feature macro: PISO_PARITY_EN adds an even-parity bit before the stop bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TICK_DIV  = 125_000_000,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              tick_s;
  logic              clr_s;
  logic              accept_s;
`ifdef PISO_PARITY_EN
  logic              par_q, par_d;

  // Even parity over the accepted word
  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction
`endif

  // Advance the shift register by one bit in the configured direction
  function automatic logic [DATA_W-1:0] shift1(input logic [DATA_W-1:0] v);
    if (MSB_FIRST != 0) begin
      return {v[DATA_W-2:0], 1'b0};
    end else begin
      return {1'b0, v[DATA_W-1:1]};
    end
  endfunction

  // Bit currently presented to the line from the shift register
  function automatic logic line_bit(input logic [DATA_W-1:0] v);
    if (MSB_FIRST != 0) begin
      return v[DATA_W-1];
    end else begin
      return v[0];
    end
  endfunction

  assign accept_s = load_valid && ready_q;
  // Holding the timer cleared while idle makes the accept edge start bit period 0
  assign clr_s    = (state_q == S_IDLE);

  bit_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // FSM state, shift register and bit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= {DATA_W{1'b0}};
      idx_q   <= {IW{1'b0}};
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, data shifting and bit counting
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_START;
          shreg_d = load_data;
          idx_d   = {IW{1'b0}};
`ifdef PISO_PARITY_EN
          par_d   = even_parity(load_data);
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          state_d = S_DATA;
          idx_d   = {IW{1'b0}};
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          if (idx_q == IW'(DATA_W - 1)) begin
`ifdef PISO_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d   = idx_q + IW'(1);
            shreg_d = shift1(shreg_q);
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (tick_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (tick_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: line level and handshake flags for the upcoming state
  always_comb begin
    tx_d    = LINE_IDLE;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    case (state_d)
      S_IDLE: begin
        tx_d    = LINE_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_START: begin
        tx_d = START_BIT;
      end
      S_DATA: begin
        tx_d = line_bit(shreg_d);
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        tx_d = par_d;
      end
`endif
      S_STOP: begin
        tx_d = STOP_BIT;
      end
      default: begin
        tx_d    = LINE_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Output registers; reset drives the line idle-high at once, aborting any frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q    <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_out     = tx_q;
  assign load_ready = ready_q;
  assign busy       = busy_q;
  // Both terms are flops; high only during the last cycle of the stop bit
  assign done       = (state_q == S_STOP) && tick_s;

endmodule
